marble_launcher: RTL and testbench

//  Top-of-board marble source: blue (left) and red (right) hoppers releasing one

---
 rtl/marble_launcher_pkg.sv | 15 +
 rtl/marble_hopper.sv | 28 ++
 rtl/marble_launcher.sv | 103 ++++++++++
 tb/tb_marble_launcher.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/marble_launcher_pkg.sv
// rtl/marble_launcher_pkg.sv - shared state encoding and side constants for the marble launcher
package marble_launcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RELEASE = 3'd1,
      ST_FLIGHT  = 3'd2,
      ST_DONE    = 3'd3,
      ST_ERROR   = 3'd4
   } state_t;

   localparam logic SIDE_BLUE = 1'b0;
   localparam logic SIDE_RED  = 1'b1;

endpackage

// File: rtl/marble_hopper.sv
// rtl/marble_hopper.sv - marble hopper counter; load beats decrement, never wraps below zero
module marble_hopper #(
   parameter int CNT_W = 4,
   parameter int INIT  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty
);

   localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= INIT_VAL;
      end else if (i_load) begin
         o_count <= INIT_VAL;
      end else if (i_dec && (o_count != '0)) begin
         o_count <= o_count - 1'b1;
      end
   end

   assign o_empty = (o_count == '0);

endmodule

// File: rtl/marble_launcher.sv
// rtl/marble_launcher.sv - top marble source: one-marble-in-flight FSM feeding the cell fabric
module marble_launcher
   import marble_launcher_pkg::*;
#(
   parameter int BLUE_COUNT = 8,
   parameter int RED_COUNT  = 8,
   parameter int CNT_W      = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_start_side,
   input  logic             i_reload,
   input  logic             i_trig_left,
   input  logic             i_trig_right,
   input  logic             i_intercepted,
   output logic             o_left,
   output logic             o_right,
   output logic [CNT_W-1:0] o_blue_left,
   output logic [CNT_W-1:0] o_red_left,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state;
   logic          side;
   logic [TW-1:0] timer;
   logic          blue_empty;
   logic          red_empty;

   // Counts drop on the edge leaving RELEASE, so the pulse and decrement share one state.
   marble_hopper #(.CNT_W(CNT_W), .INIT(BLUE_COUNT)) u_blue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (i_reload),
      .i_dec   ((state == ST_RELEASE) && (side == SIDE_BLUE)),
      .o_count (o_blue_left),
      .o_empty (blue_empty)
   );

   marble_hopper #(.CNT_W(CNT_W), .INIT(RED_COUNT)) u_red (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (i_reload),
      .i_dec   ((state == ST_RELEASE) && (side == SIDE_RED)),
      .o_count (o_red_left),
      .o_empty (red_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
         side  <= SIDE_BLUE;
         timer <= '0;
      end else if (i_reload) begin
         state <= ST_IDLE;
         timer <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  side  <= i_start_side;
                  state <= (i_start_side ? red_empty : blue_empty) ? ST_DONE : ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               timer <= '0;
               state <= ST_FLIGHT;
            end
            ST_FLIGHT: begin
               if (i_trig_left && i_trig_right) begin
                  state <= ST_ERROR;
               end else if (i_intercepted) begin
                  state <= ST_DONE;
               end else if (i_trig_left) begin
                  side  <= SIDE_BLUE;
                  state <= blue_empty ? ST_DONE : ST_RELEASE;
               end else if (i_trig_right) begin
                  side  <= SIDE_RED;
                  state <= red_empty ? ST_DONE : ST_RELEASE;
               end else if ((TIMEOUT != 0) && (timer == T_LAST)) begin
                  state <= ST_ERROR;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= state;
         endcase
      end
   end

   assign o_left  = (state == ST_RELEASE) && (side == SIDE_BLUE);
   assign o_right = (state == ST_RELEASE) && (side == SIDE_RED);
   assign o_busy  = (state == ST_RELEASE) || (state == ST_FLIGHT);
   assign o_done  = (state == ST_DONE);
   assign o_error = (state == ST_ERROR);

endmodule

// File: tb/tb_marble_launcher.sv
// tb/tb_marble_launcher.sv - directed self-checking bench for marble_launcher
module tb_marble_launcher;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_start_side = 1'b0;
   logic       i_reload = 1'b0;
   logic       i_trig_left = 1'b0;
   logic       i_trig_right = 1'b0;
   logic       i_intercepted = 1'b0;
   logic       o_left, o_right, o_busy, o_done, o_error;
   logic [3:0] o_blue_left, o_red_left;

   int vecs = 0;
   int errs = 0;
   int left_pulses = 0;
   int right_pulses = 0;

   marble_launcher #(
      .BLUE_COUNT(8), .RED_COUNT(8), .CNT_W(4), .TIMEOUT(64)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_start_side  (i_start_side),
      .i_reload      (i_reload),
      .i_trig_left   (i_trig_left),
      .i_trig_right  (i_trig_right),
      .i_intercepted (i_intercepted),
      .o_left        (o_left),
      .o_right       (o_right),
      .o_blue_left   (o_blue_left),
      .o_red_left    (o_red_left),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_error       (o_error)
   );

   always #5 i_clk = ~i_clk;

   // Pulse monitor: each one-cycle pulse spans exactly one falling edge.
   always @(negedge i_clk) begin
      if (o_left)  left_pulses++;
      if (o_right) right_pulses++;
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic apply_reset();
      i_rst_n = 1'b0;
      step();
      step();
      i_rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      vecs++; if (o_blue_left !== 4'd8) begin errs++; $display("FAIL reset_blue: got %0d want 8", o_blue_left); end
      vecs++; if (o_red_left !== 4'd8) begin errs++; $display("FAIL reset_red: got %0d want 8", o_red_left); end
      vecs++; if ({o_left, o_right, o_busy, o_done, o_error} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b want 00000", {o_left, o_right, o_busy, o_done, o_error}); end
   endtask

   task automatic test_blue_run();
      i_start = 1'b1; i_start_side = 1'b0;
      step();
      i_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         vecs++; if (o_left !== 1'b1 || o_right !== 1'b0) begin errs++; $display("FAIL blue_pulse%0d: got l=%b r=%b want l=1 r=0", k, o_left, o_right); end
         step();
         vecs++; if (o_blue_left !== 4'(7 - k) || o_left !== 1'b0) begin errs++; $display("FAIL blue_count%0d: got %0d l=%b want %0d l=0", k, o_blue_left, o_left, 7 - k); end
         step();
         i_trig_left = 1'b1;
         step();
         i_trig_left = 1'b0;
      end
      vecs++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errs++; $display("FAIL blue_done: got done=%b busy=%b want 1 0", o_done, o_busy); end
      vecs++; if (o_blue_left !== 4'd0 || o_red_left !== 4'd8) begin errs++; $display("FAIL blue_final_counts: got %0d/%0d want 0/8", o_blue_left, o_red_left); end
      vecs++; if (left_pulses !== 8 || right_pulses !== 0) begin errs++; $display("FAIL blue_pulse_total: got %0d/%0d want 8/0", left_pulses, right_pulses); end
      i_start = 1'b1;
      step(); step();
      i_start = 1'b0;
      vecs++; if (o_done !== 1'b1 || left_pulses !== 8) begin errs++; $display("FAIL done_sticky: got done=%b pulses=%0d want 1 8", o_done, left_pulses); end
   endtask

   task automatic test_alternate();
      i_reload = 1'b1; step(); i_reload = 1'b0;
      vecs++; if (o_done !== 1'b0 || o_blue_left !== 4'd8) begin errs++; $display("FAIL reload_from_done: got done=%b blue=%0d want 0 8", o_done, o_blue_left); end
      i_start = 1'b1; i_start_side = 1'b1;
      step();
      i_start = 1'b0;
      vecs++; if (o_right !== 1'b1 || o_left !== 1'b0) begin errs++; $display("FAIL alt_first_right: got l=%b r=%b want 0 1", o_left, o_right); end
      step();
      vecs++; if (o_red_left !== 4'd7 || o_right !== 1'b0) begin errs++; $display("FAIL alt_red7: got %0d r=%b want 7 0", o_red_left, o_right); end
      i_trig_left = 1'b1; step(); i_trig_left = 1'b0;
      vecs++; if (o_left !== 1'b1) begin errs++; $display("FAIL alt_left1: got %b want 1", o_left); end
      step();
      vecs++; if (o_blue_left !== 4'd7) begin errs++; $display("FAIL alt_blue7: got %0d want 7", o_blue_left); end
      i_trig_right = 1'b1; step(); i_trig_right = 1'b0;
      vecs++; if (o_right !== 1'b1) begin errs++; $display("FAIL alt_right2: got %b want 1", o_right); end
      step();
      i_trig_left = 1'b1; step(); i_trig_left = 1'b0;
      vecs++; if (o_left !== 1'b1) begin errs++; $display("FAIL alt_left2: got %b want 1", o_left); end
      step();
      vecs++; if (o_blue_left !== 4'd6 || o_red_left !== 4'd6) begin errs++; $display("FAIL alt_counts: got %0d/%0d want 6/6", o_blue_left, o_red_left); end
   endtask

   task automatic test_both_triggers();
      int lp, rp;
      lp = left_pulses; rp = right_pulses;
      i_trig_left = 1'b1; i_trig_right = 1'b1;
      step();
      i_trig_left = 1'b0; i_trig_right = 1'b0;
      vecs++; if (o_error !== 1'b1 || o_busy !== 1'b0) begin errs++; $display("FAIL both_trig_error: got err=%b busy=%b want 1 0", o_error, o_busy); end
      step();
      vecs++; if (left_pulses !== lp || right_pulses !== rp) begin errs++; $display("FAIL both_trig_pulse: got %0d/%0d want %0d/%0d", left_pulses, right_pulses, lp, rp); end
      vecs++; if (o_blue_left !== 4'd6 || o_red_left !== 4'd6) begin errs++; $display("FAIL both_trig_counts: got %0d/%0d want 6/6", o_blue_left, o_red_left); end
      i_reload = 1'b1; step(); i_reload = 1'b0;
      vecs++; if (o_error !== 1'b0 || o_blue_left !== 4'd8 || o_red_left !== 4'd8) begin errs++; $display("FAIL error_reload: got err=%b %0d/%0d want 0 8/8", o_error, o_blue_left, o_red_left); end
   endtask

   task automatic test_intercept();
      int lp, rp;
      i_start = 1'b1; i_start_side = 1'b0;
      step();
      i_start = 1'b0;
      step();
      rp = right_pulses; lp = left_pulses;
      i_intercepted = 1'b1; i_trig_right = 1'b1;
      step();
      i_intercepted = 1'b0; i_trig_right = 1'b0;
      vecs++; if (o_done !== 1'b1 || o_right !== 1'b0) begin errs++; $display("FAIL intercept_done: got done=%b r=%b want 1 0", o_done, o_right); end
      vecs++; if (o_blue_left !== 4'd7 || o_red_left !== 4'd8) begin errs++; $display("FAIL intercept_counts: got %0d/%0d want 7/8", o_blue_left, o_red_left); end
      // Triggers in DONE must not release anything.
      i_trig_left = 1'b1; step(); i_trig_left = 1'b0;
      i_trig_right = 1'b1; step(); i_trig_right = 1'b0;
      step();
      vecs++; if (left_pulses !== lp || right_pulses !== rp || o_done !== 1'b1) begin errs++; $display("FAIL done_trig_ignored: got %0d/%0d done=%b want %0d/%0d 1", left_pulses, right_pulses, o_done, lp, rp); end
   endtask

   task automatic test_timeout();
      int n;
      i_reload = 1'b1; step(); i_reload = 1'b0;
      i_start = 1'b1; i_start_side = 1'b1;
      step();
      i_start = 1'b0;
      step();
      vecs++; if (o_busy !== 1'b1 || o_red_left !== 4'd7) begin errs++; $display("FAIL timeout_flight: got busy=%b red=%0d want 1 7", o_busy, o_red_left); end
      n = 0;
      while (o_error !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      vecs++; if (n !== 64) begin errs++; $display("FAIL timeout_cycles: got %0d want 64", n); end
      i_reload = 1'b1; step(); i_reload = 1'b0;
      vecs++; if (o_error !== 1'b0 || o_busy !== 1'b0 || o_blue_left !== 4'd8 || o_red_left !== 4'd8) begin errs++; $display("FAIL timeout_reload: got err=%b busy=%b %0d/%0d want 0 0 8/8", o_error, o_busy, o_blue_left, o_red_left); end
   endtask

   task automatic test_reset_mid_flight();
      int lp, rp;
      i_start = 1'b1; i_start_side = 1'b0;
      step();
      i_start = 1'b0;
      step();
      lp = left_pulses; rp = right_pulses;
      i_rst_n = 1'b0;
      #1;
      vecs++; if (o_busy !== 1'b0 || o_blue_left !== 4'd8 || o_red_left !== 4'd8) begin errs++; $display("FAIL async_reset: got busy=%b %0d/%0d want 0 8/8", o_busy, o_blue_left, o_red_left); end
      i_trig_left = 1'b1;
      step();
      i_rst_n = 1'b1;
      step();
      i_trig_left = 1'b0; i_trig_right = 1'b1;
      step(); step();
      i_trig_right = 1'b0;
      vecs++; if (left_pulses !== lp || right_pulses !== rp || o_busy !== 1'b0) begin errs++; $display("FAIL idle_trig_ignored: got %0d/%0d busy=%b want %0d/%0d 0", left_pulses, right_pulses, o_busy, lp, rp); end
      vecs++; if (o_blue_left !== 4'd8 || o_red_left !== 4'd8) begin errs++; $display("FAIL idle_counts: got %0d/%0d want 8/8", o_blue_left, o_red_left); end
   endtask

   initial begin
      test_reset();
      test_blue_run();
      test_alternate();
      test_both_triggers();
      test_intercept();
      test_timeout();
      test_reset_mid_flight();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
